topeira_game_ctrl: RTL

Round sequencer for the whack-a-mole game on the DE2 board. It picks a pseudo-random hole and lights that hole's mole for a timed window. It checks the player's key hits against the lit hole and keeps a two-digit BCD score for the seven-segment decoders. It sits between the synchronized, debounced KEY inputs and the LEDG / HEX0 / HEX1 drivers, and it owns all game timing.

---
 rtl/topeira_game_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/topeira_game_ctrl.sv
// Whack-a-mole round sequencer: LFSR hole pick, timed mole window,
// key-edge scoring with a saturating two-digit BCD score.
//
// Ports:
//   CLOCK_50   in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   level, sampled only in IDLE/DONE
//   hit[3:0]   in   debounced key levels, one per hole
//   mole[3:0]  out  one-hot lit hole, 0 when dark
//   score_ones out  BCD units digit
//   score_tens out  BCD tens digit
//   hit_ok     out  1-cycle pulse on a correct hit
//   miss       out  1-cycle pulse on a wrong key or timeout
//   busy       out  high in SHOW and GAP
//   game_over  out  high in DONE
module topeira_game_ctrl #(
  parameter int         TICK_DIV   = 50_000_000,
  parameter int         SHOW_TICKS = 2,
  parameter int         GAP_TICKS  = 1,
  parameter int         ROUNDS     = 20,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] hit,
  output logic [3:0] mole,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       hit_ok,
  output logic       miss,
  output logic       busy,
  output logic       game_over
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX =
    (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CYC_LAST  = CW'(TICK_DIV - 1);
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [7:0]    ROUNDS_L  = 8'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [7:0]      r_lfsr;
  logic [1:0]      r_prev;
  logic [3:0]      r_hit_q;
  logic [CW-1:0]   r_cyc;
  logic [TW-1:0]   r_tick;
  logic [7:0]      r_round;

  logic            w_fb;
  logic [1:0]      w_pos;
  logic [3:0]      w_edge;
  logic [3:0]      w_mask;
  logic [3:0]      w_new_mask;
  logic            w_wrap;
  logic [CW-1:0]   w_cyc_nxt;
  logic [TW-1:0]   w_tick_nxt;
  logic            w_show_end;
  logic            w_gap_end;
  logic [7:0]      w_round_nxt;
  logic [3:0]      w_ones_nxt;
  logic [3:0]      w_tens_nxt;

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Bump the candidate so a hole is never lit twice in a row.
  assign w_pos = (r_lfsr[1:0] == r_prev) ?
                 r_lfsr[1:0] + 2'd1 : r_lfsr[1:0];

  assign w_edge     = hit & ~r_hit_q;
  assign w_mask     = 4'b0001 << r_prev;
  assign w_new_mask = 4'b0001 << w_pos;

  assign w_wrap     = (r_cyc == CYC_LAST);
  assign w_cyc_nxt  = w_wrap ? '0 : r_cyc + CW'(1);
  assign w_tick_nxt = w_wrap ? r_tick + TW'(1) : r_tick;
  assign w_show_end = w_wrap && (r_tick == SHOW_LAST);
  assign w_gap_end  = w_wrap && (r_tick == GAP_LAST);

  assign w_round_nxt = r_round + 8'd1;

  always_comb begin
    w_ones_nxt = score_ones;
    w_tens_nxt = score_tens;
    if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
      if (score_ones == 4'd9) begin
        w_ones_nxt = 4'd0;
        w_tens_nxt = score_tens + 4'd1;
      end else begin
        w_ones_nxt = score_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_prev     <= 2'd0;
      r_hit_q    <= 4'd0;
      r_cyc      <= '0;
      r_tick     <= '0;
      r_round    <= 8'd0;
      mole       <= 4'd0;
      score_ones <= 4'd0;
      score_tens <= 4'd0;
      hit_ok     <= 1'b0;
      miss       <= 1'b0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      r_lfsr  <= {r_lfsr[6:0], w_fb};
      r_hit_q <= hit;
      hit_ok  <= 1'b0;
      miss    <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            score_ones <= 4'd0;
            score_tens <= 4'd0;
            r_round    <= 8'd0;
            r_prev     <= w_pos;
            mole       <= w_new_mask;
            r_cyc      <= '0;
            r_tick     <= '0;
            busy       <= 1'b1;
            game_over  <= 1'b0;
            r_state    <= S_SHOW;
          end
        end
        S_SHOW: begin
          r_cyc  <= w_cyc_nxt;
          r_tick <= w_tick_nxt;
          if (w_edge != 4'd0) begin
            // Any stray key in the same cycle spoils a correct hit.
            if (w_edge == w_mask) begin
              hit_ok     <= 1'b1;
              score_ones <= w_ones_nxt;
              score_tens <= w_tens_nxt;
            end else begin
              miss <= 1'b1;
            end
            mole    <= 4'd0;
            r_cyc   <= '0;
            r_tick  <= '0;
            r_state <= S_GAP;
          end else if (w_show_end) begin
            miss    <= 1'b1;
            mole    <= 4'd0;
            r_cyc   <= '0;
            r_tick  <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_cyc  <= w_cyc_nxt;
          r_tick <= w_tick_nxt;
          if (w_gap_end) begin
            r_round <= w_round_nxt;
            if (w_round_nxt == ROUNDS_L) begin
              busy      <= 1'b0;
              game_over <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_prev  <= w_pos;
              mole    <= w_new_mask;
              r_cyc   <= '0;
              r_tick  <= '0;
              r_state <= S_SHOW;
            end
          end
        end
      endcase
    end
  end

endmodule
